// File: rtl/gshare_pkg.sv
// Shared types and PC slicing helpers for the gshare branch prediction unit.
package gshare_pkg;

    // Widths that fix the BTB entry layout.
    localparam int PKG_XLEN  = 32;
    localparam int PKG_TAG_W = 10;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic                  is_jump;
        logic [PKG_TAG_W-1:0]  tag;
        logic [PKG_XLEN-3:0]   target;
    } btb_entry_t;

    typedef enum logic {INIT, RUN} bpu_state_e;

    // Word address of a PC; callers truncate to their index width.
    function automatic logic [PKG_XLEN-1:0] word_index(input logic [PKG_XLEN-1:0] pc);
        return pc >> 2;
    endfunction

    // PC bits above a table index of idx_w bits; callers truncate to the tag width.
    function automatic logic [PKG_XLEN-1:0] tag_field(input logic [PKG_XLEN-1:0] pc,
                                                      input int unsigned       idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/gshare_bpu_sat_ctr2.sv
// Two-bit saturating counter next-state function.
module sat_ctr2
    import gshare_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    // Step toward taken/not-taken, holding at the ends.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_bpu.sv
// G-share branch predictor: PHT indexed by PC^GHR for direction, tagged BTB
// for targets, speculative GHR with checkpoint recovery, table init sweep.
module gshare_bpu
    import gshare_pkg::*;
#(
    parameter int   XLEN      = 32,
    parameter int   PHT_IDX_W = 10,
    parameter int   BTB_IDX_W = 8,
    parameter int   TAG_W     = 10,
    parameter int   GHR_W     = 10,
    parameter ctr_t CTR_INIT  = 2'b01,
    parameter int   CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fetch_valid,
    input  logic [XLEN-1:0]  i_fetch_pc,
    output logic             o_ready,
    output logic             o_pred_hit,
    output logic             o_pred_taken,
    output logic [XLEN-1:0]  o_pred_target,
    output logic [GHR_W-1:0] o_pred_ghr,
    input  logic             i_upd_valid,
    input  logic [XLEN-1:0]  i_upd_pc,
    input  logic [GHR_W-1:0] i_upd_ghr,
    input  logic             i_upd_is_branch,
    input  logic             i_upd_is_jump,
    input  logic             i_upd_taken,
    input  logic [XLEN-1:0]  i_upd_target,
    input  logic             i_upd_mispred,
    output logic [CNT_W-1:0] o_upd_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int SWEEP_W = (PHT_IDX_W > BTB_IDX_W) ? PHT_IDX_W : BTB_IDX_W;
    localparam int PHT_N   = 1 << PHT_IDX_W;
    localparam int BTB_N   = 1 << BTB_IDX_W;

    bpu_state_e         state_q, state_d;
    logic [SWEEP_W-1:0] ptr_q, ptr_d;
    logic               ready_q;
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic [CNT_W-1:0]   upd_cnt_q, mispred_cnt_q;

    ctr_t       pht_q [PHT_N];
    btb_entry_t btb_q [BTB_N];

    logic init_we, sweep_last, pht_sweep_en, btb_sweep_en;

    // Fetch-side lookup
    logic [PHT_IDX_W-1:0] f_pht_idx;
    logic [BTB_IDX_W-1:0] f_btb_idx;
    logic [TAG_W-1:0]     f_tag;
    btb_entry_t           f_ent;
    logic                 f_hit, f_taken;

    // Update-side training
    logic [PHT_IDX_W-1:0] u_pht_idx;
    logic [BTB_IDX_W-1:0] u_btb_idx;
    logic [TAG_W-1:0]     u_tag;
    ctr_t                 pht_nxt;
    btb_entry_t           btb_wdata;
    logic                 upd_go, pht_we, btb_we;

    assign sweep_last = (ptr_q == '1);

    // FSM state register and sweep pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_q == RUN);
        end
    end

    // FSM next state: sweep every entry once, then run forever
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                ptr_d = ptr_q + SWEEP_W'(1);
                if (sweep_last) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // FSM outputs: sweep write enables per table
    always_comb begin
        init_we      = (state_q == INIT);
        pht_sweep_en = init_we && (32'(ptr_q) < PHT_N);
        btb_sweep_en = init_we && (32'(ptr_q) < BTB_N);
    end

    // Combinational prediction; gated off until the tables are initialised
    always_comb begin
        f_pht_idx = PHT_IDX_W'(word_index(i_fetch_pc)) ^ PHT_IDX_W'(ghr_q);
        f_btb_idx = BTB_IDX_W'(word_index(i_fetch_pc));
        f_tag     = TAG_W'(tag_field(i_fetch_pc, BTB_IDX_W));
        f_ent     = btb_q[f_btb_idx];
        f_hit     = ready_q && f_ent.valid && (f_ent.tag == f_tag);
        f_taken   = f_hit && (f_ent.is_jump || pht_q[f_pht_idx][1]);
    end

    // Training controls and write data
    always_comb begin
        upd_go            = ready_q && i_upd_valid;
        u_pht_idx         = PHT_IDX_W'(word_index(i_upd_pc)) ^ PHT_IDX_W'(i_upd_ghr);
        u_btb_idx         = BTB_IDX_W'(word_index(i_upd_pc));
        u_tag             = TAG_W'(tag_field(i_upd_pc, BTB_IDX_W));
        pht_we            = upd_go && i_upd_is_branch;
        btb_we            = upd_go && (i_upd_is_jump || (i_upd_is_branch && i_upd_taken));
        btb_wdata.valid   = 1'b1;
        btb_wdata.is_jump = i_upd_is_jump;
        btb_wdata.tag     = u_tag;
        btb_wdata.target  = (XLEN-2)'(i_upd_target >> 2);
    end

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (pht_q[u_pht_idx]),
        .taken_i (i_upd_taken),
        .ctr_o   (pht_nxt)
    );

    // Table writes: the sweep owns the tables until it finishes
    always_ff @(posedge i_clk) begin
        if (init_we) begin
            if (pht_sweep_en) pht_q[PHT_IDX_W'(ptr_q)] <= CTR_INIT;
            if (btb_sweep_en) btb_q[BTB_IDX_W'(ptr_q)] <= '0;
        end else begin
            if (pht_we) pht_q[u_pht_idx] <= pht_nxt;
            if (btb_we) btb_q[u_btb_idx] <= btb_wdata;
        end
    end

    // Next GHR: recovery from EX wins over a speculative fetch shift
    always_comb begin
        ghr_d = ghr_q;
        if (upd_go && i_upd_mispred)
            ghr_d = GHR_W'({i_upd_ghr, i_upd_taken});
        else if (i_fetch_valid && f_hit)
            ghr_d = GHR_W'({ghr_q, f_taken});
    end

    // GHR and performance counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ghr_q         <= '0;
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            if (upd_go) upd_cnt_q <= upd_cnt_q + CNT_W'(1);
            if (upd_go && i_upd_mispred) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign o_ready       = ready_q;
    assign o_pred_hit    = f_hit;
    assign o_pred_taken  = f_taken;
    assign o_pred_target = f_hit ? {f_ent.target, 2'b00} : '0;
    assign o_pred_ghr    = ghr_q;
    assign o_upd_cnt     = upd_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_gshare_bpu.sv
// Directed bench for gshare_bpu with hand-computed expectations.
module tb_gshare_bpu;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        ready, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic [9:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [9:0]  upd_ghr;
    logic        upd_is_branch, upd_is_jump, upd_taken, upd_mispred;
    logic [31:0] upd_target;
    logic [31:0] upd_cnt, mispred_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    gshare_bpu dut (
        .i_clk           (clk_sys),
        .i_rst           (rst),
        .i_fetch_valid   (fetch_valid),
        .i_fetch_pc      (fetch_pc),
        .o_ready         (ready),
        .o_pred_hit      (pred_hit),
        .o_pred_taken    (pred_taken),
        .o_pred_target   (pred_target),
        .o_pred_ghr      (pred_ghr),
        .i_upd_valid     (upd_valid),
        .i_upd_pc        (upd_pc),
        .i_upd_ghr       (upd_ghr),
        .i_upd_is_branch (upd_is_branch),
        .i_upd_is_jump   (upd_is_jump),
        .i_upd_taken     (upd_taken),
        .i_upd_target    (upd_target),
        .i_upd_mispred   (upd_mispred),
        .o_upd_cnt       (upd_cnt),
        .o_mispred_cnt   (mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one update for one clock edge, starting and ending on a falling edge.
    task automatic do_upd(input logic [31:0] pc, input logic [9:0] ghr, input logic br,
                          input logic jmp, input logic tk, input logic [31:0] tgt,
                          input logic mp);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_ghr       = ghr;
        upd_is_branch = br;
        upd_is_jump   = jmp;
        upd_taken     = tk;
        upd_target    = tgt;
        upd_mispred   = mp;
        @(posedge clk_sys);
        @(negedge clk_sys);
        upd_valid     = 1'b0;
        upd_mispred   = 1'b0;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc);
        fetch_valid = v;
        fetch_pc    = pc;
        #1;
    endtask

    initial begin
        logic early_ready;
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_is_branch = 1'b0;
        upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_upd_cnt", upd_cnt, 0);
        chk("rst_ghr", 32'(pred_ghr), 0);
        rst = 1'b0;

        // Sweep: ready must stay low for 1024 edges, high on the 1025th.
        early_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            if (ready) early_ready = 1'b1;
        end
        chk("ready_low_1024", 32'(early_ready), 0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("ready_1025", 32'(ready), 1);

        set_fetch(1'b0, 32'h100);
        chk("cold_hit", 32'(pred_hit), 0);
        chk("cold_taken", 32'(pred_taken), 0);
        chk("cold_target", pred_target, 0);

        // Two taken updates: PHT[0x40] 01 -> 10 -> 11.
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        set_fetch(1'b0, 32'h100);
        chk("train_hit", 32'(pred_hit), 1);
        chk("train_taken", 32'(pred_taken), 1);
        chk("train_target", pred_target, 32'h80);
        chk("train_upd_cnt", upd_cnt, 2);

        // Speculative shift on a taken hit.
        set_fetch(1'b1, 32'h100);
        @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        chk("spec_ghr", 32'(pred_ghr), 32'h001);
        // GHR=1 -> PHT[0x41] still weakly not-taken.
        chk("ghr1_hit", 32'(pred_hit), 1);
        chk("ghr1_taken", 32'(pred_taken), 0);
        // Recovery beats the same-cycle fetch shift; non-control update trains nothing.
        do_upd(32'h100, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        set_fetch(1'b0, 32'h100);
        chk("recover_ghr", 32'(pred_ghr), 0);
        chk("recover_upd_cnt", upd_cnt, 3);
        chk("recover_mis_cnt", mispred_cnt, 1);
        chk("recover_taken", 32'(pred_taken), 1);

        // Saturating down: 11 -> 10 -> 01 -> 00 -> 00, then back up.
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 chk("sat_dn1_taken", 32'(pred_taken), 1);
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 chk("sat_dn2_taken", 32'(pred_taken), 0);
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 chk("sat_floor_taken", 32'(pred_taken), 0);
        chk("sat_floor_hit", 32'(pred_hit), 1);
        chk("nt_keeps_target", pred_target, 32'h80);
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        #1 chk("sat_up1_taken", 32'(pred_taken), 0);
        do_upd(32'h100, 10'h0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        #1 chk("sat_up2_taken", 32'(pred_taken), 1);
        chk("sat_upd_cnt", upd_cnt, 9);

        // Tag alias: same BTB index, tag 1; miss must not shift the GHR.
        set_fetch(1'b1, 32'h500);
        chk("alias_hit", 32'(pred_hit), 0);
        chk("alias_taken", 32'(pred_taken), 0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("miss_no_shift", 32'(pred_ghr), 0);
        set_fetch(1'b0, 32'h200);

        // Jump: taken regardless of weakly not-taken PHT entry.
        do_upd(32'h200, 10'h0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
        #1;
        chk("jump_hit", 32'(pred_hit), 1);
        chk("jump_taken", 32'(pred_taken), 1);
        chk("jump_target", pred_target, 32'h400);
        chk("jump_upd_cnt", upd_cnt, 10);

        // Same-cycle read/write: old contents now, new contents next cycle.
        set_fetch(1'b0, 32'h300);
        upd_valid = 1'b1; upd_pc = 32'h300; upd_ghr = '0; upd_is_branch = 1'b0;
        upd_is_jump = 1'b1; upd_taken = 1'b1; upd_target = 32'h600; upd_mispred = 1'b0;
        #1 chk("rw_old_hit", 32'(pred_hit), 0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        upd_valid = 1'b0;
        #1;
        chk("rw_new_hit", 32'(pred_hit), 1);
        chk("rw_new_target", pred_target, 32'h600);
        chk("rw_mis_cnt", mispred_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
